// File: rtl/dest_reg_pipe_pkg.sv
// Shared definitions for the destination-register pipeline: register
// address width, hard-wired zero register, forwarding-select codes and
// the per-slot record carried through EX, MEM and WB.
package dest_reg_pipe_pkg;

  localparam int unsigned AW = 5;
  localparam logic [AW-1:0] ZERO_REG = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic [AW-1:0] wreg;
    logic          wen;
    logic          load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A write to the zero register is never a real write.
  function automatic slot_t mask_zero(input slot_t s);
    slot_t r;
    r     = s;
    r.wen = s.wen & (s.wreg != ZERO_REG);
    return r;
  endfunction

  // True when the slot holds a live write to the register being read.
  function automatic logic slot_hit(input logic [AW-1:0] src,
                                    input logic          use_src,
                                    input slot_t         s);
    return use_src && (src != ZERO_REG) && s.wen && (s.wreg == src);
  endfunction

endpackage

// File: rtl/dest_reg_pipe_slot.sv
// One pipeline slot (EX, MEM or WB) holding {wreg, wen, load}.
// hold keeps the contents, bubble loads an empty record, otherwise the
// incoming record is captured with wen cleared for the zero register.
module dest_slot
  import dest_reg_pipe_pkg::*;
(
  input  logic  clk,
  input  logic  clrn,
  input  slot_t d_i,
  input  logic  bubble_i,
  input  logic  hold_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  // Next contents: hold beats bubble, bubble beats capture.
  always_comb begin
    slot_d = slot_q;
    if (!hold_i) begin
      if (bubble_i) begin
        slot_d = SLOT_BUBBLE;
      end else begin
        slot_d = mask_zero(d_i);
      end
    end
  end

  // Slot register, cleared asynchronously so in-flight writes are dropped.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      slot_q <= SLOT_BUBBLE;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline: carries each instruction's destination,
// write-enable and load flag through EX/MEM/WB and derives the ALU operand
// forwarding selects, the load-use stall and the register-file write port.
// Optional build macro DEST_WB_FWD_EN: when defined, a match in WB forwards
// the WB write data (code 11); when undefined the register file is assumed
// write-before-read and WB matches select the register file (code 00).
module dest_reg_pipe
  import dest_reg_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] id_wreg,
  input  logic          id_wen,
  input  logic          id_load,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          freeze,
  input  logic          flush,
  output logic [AW-1:0] ex_wreg,
  output logic [AW-1:0] mem_wreg,
  output logic [AW-1:0] wb_wreg,
  output logic          wb_wen,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          lu_stall
);

  slot_t id_rec;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  logic  ex_bubble;
  logic  unused_load_bits;

  assign id_rec    = '{wreg: id_wreg, wen: id_wen, load: id_load};
  assign ex_bubble = flush | lu_stall;

  dest_slot u_ex (
    .clk      (clk),
    .clrn     (clrn),
    .d_i      (id_rec),
    .bubble_i (ex_bubble),
    .hold_i   (freeze),
    .q_o      (ex_q)
  );

  dest_slot u_mem (
    .clk      (clk),
    .clrn     (clrn),
    .d_i      (ex_q),
    .bubble_i (1'b0),
    .hold_i   (freeze),
    .q_o      (mem_q)
  );

  dest_slot u_wb (
    .clk      (clk),
    .clrn     (clrn),
    .d_i      (mem_q),
    .bubble_i (1'b0),
    .hold_i   (freeze),
    .q_o      (wb_q)
  );

  // Load in EX whose result an ID source needs: hold ID for one cycle.
  always_comb begin
    lu_stall = ex_q.load & ex_q.wen &
               ((id_use_rs & (id_rs == ex_q.wreg)) |
                (id_use_rt & (id_rt == ex_q.wreg)));
  end

  // Operand A select, youngest producer first; a load in EX cannot forward.
  always_comb begin
    fwd_a = FWD_RF;
    if (slot_hit(id_rs, id_use_rs, ex_q) && !ex_q.load) begin
      fwd_a = FWD_EX;
    end else if (slot_hit(id_rs, id_use_rs, mem_q)) begin
      fwd_a = FWD_MEM;
`ifdef DEST_WB_FWD_EN
    end else if (slot_hit(id_rs, id_use_rs, wb_q)) begin
      fwd_a = FWD_WB;
`endif
    end
  end

  // Operand B select, same priority as operand A.
  always_comb begin
    fwd_b = FWD_RF;
    if (slot_hit(id_rt, id_use_rt, ex_q) && !ex_q.load) begin
      fwd_b = FWD_EX;
    end else if (slot_hit(id_rt, id_use_rt, mem_q)) begin
      fwd_b = FWD_MEM;
`ifdef DEST_WB_FWD_EN
    end else if (slot_hit(id_rt, id_use_rt, wb_q)) begin
      fwd_b = FWD_WB;
`endif
    end
  end

  // Load flags past EX only matter for the data path, not for this block.
  assign unused_load_bits = mem_q.load ^ wb_q.load;

  assign ex_wreg  = ex_q.wreg;
  assign mem_wreg = mem_q.wreg;
  assign wb_wreg  = wb_q.wreg;
  assign wb_wen   = wb_q.wen;

endmodule

// File: tb/tb_dest_reg_pipe.sv
module tb_dest_reg_pipe;

  logic       clk = 1'b0;
  logic       clrn;
  logic [4:0] id_wreg, id_rs, id_rt;
  logic       id_wen, id_load, id_use_rs, id_use_rt;
  logic       freeze, flush;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic       wb_wen;
  logic [1:0] fwd_a, fwd_b;
  logic       lu_stall;
  logic [20:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dest_reg_pipe dut (
    .clk       (clk),
    .clrn      (clrn),
    .id_wreg   (id_wreg),
    .id_wen    (id_wen),
    .id_load   (id_load),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .freeze    (freeze),
    .flush     (flush),
    .ex_wreg   (ex_wreg),
    .mem_wreg  (mem_wreg),
    .wb_wreg   (wb_wreg),
    .wb_wen    (wb_wen),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .lu_stall  (lu_stall)
  );

  assign dut_vec = {ex_wreg, mem_wreg, wb_wreg, wb_wen, fwd_a, fwd_b, lu_stall};

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [4:0] wreg;
    logic       wen;
    logic       load;
  } ins_t;

  ins_t pipe [3];

`ifdef DEST_WB_FWD_EN
  localparam logic [1:0] WB_CODE = 2'b11;
`else
  localparam logic [1:0] WB_CODE = 2'b00;
`endif

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{wreg: 5'd0, wen: 1'b0, load: 1'b0};
  endfunction

  function automatic logic m_stall();
    return pipe[0].load && pipe[0].wen &&
           ((id_use_rs && id_rs == pipe[0].wreg) || (id_use_rt && id_rt == pipe[0].wreg));
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic use_src);
    if (!use_src || src == 5'd0) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].wen && pipe[i].wreg == src) begin
        if (i == 0 && pipe[0].load) continue;
        if (i == 0) return 2'b01;
        if (i == 1) return 2'b10;
        return WB_CODE;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic [20:0] exp_vec();
    return {pipe[0].wreg, pipe[1].wreg, pipe[2].wreg, pipe[2].wen,
            m_fwd(id_rs, id_use_rs), m_fwd(id_rt, id_use_rt), m_stall()};
  endfunction

  task automatic drive(input logic [4:0] w, input logic we, input logic ld,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt);
    id_wreg = w;  id_wen = we;  id_load = ld;
    id_rs = rs;   id_use_rs = urs;
    id_rt = rt;   id_use_rt = urt;
  endtask

  // One rising edge; the model advances using the inputs as seen at the edge.
  task automatic tick();
    ins_t nx;
    logic bub;
    @(posedge clk);
    if (!clrn) begin
      model_clear();
    end else if (!freeze) begin
      bub = flush || m_stall();
      nx.wreg = bub ? 5'd0 : id_wreg;
      nx.wen  = bub ? 1'b0 : (id_wen && id_wreg != 5'd0);
      nx.load = bub ? 1'b0 : id_load;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nx;
    end
    #2;
  endtask

  task automatic test_reset();
    clrn = 1'b0; freeze = 1'b0; flush = 1'b0;
    drive(5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
    model_clear();
    #12;
    n_checks++;
    if (dut_vec !== 21'd0) $display("FAIL reset_outputs: got=%h expected=%h", dut_vec, 21'd0);
    else n_pass++;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    clrn = 1'b1;
    tick();
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL reset_release: got=%h expected=%h", dut_vec, exp_vec());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (fwd_a !== 2'b01) $display("FAIL b2b_fwd_ex: fwd_a=%b expected=01", fwd_a);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (fwd_a !== 2'b10) $display("FAIL b2b_fwd_mem: fwd_a=%b expected=10", fwd_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    #1;
    n_checks++;
    if (lu_stall !== 1'b1) $display("FAIL lu_stall_set: lu_stall=%b expected=1", lu_stall);
    else n_pass++;
    n_checks++;
    if (fwd_b !== 2'b00) $display("FAIL lu_no_ex_fwd: fwd_b=%b expected=00", fwd_b);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (lu_stall !== 1'b0) $display("FAIL lu_stall_one_cycle: lu_stall=%b expected=0", lu_stall);
    else n_pass++;
    n_checks++;
    if (ex_wreg !== 5'd0 || mem_wreg !== 5'd9)
      $display("FAIL lu_bubble: ex_wreg=%0d mem_wreg=%0d expected 0 and 9", ex_wreg, mem_wreg);
    else n_pass++;
    n_checks++;
    if (fwd_b !== 2'b10) $display("FAIL lu_fwd_mem: fwd_b=%b expected=10", fwd_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_reg();
    drive(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (fwd_a !== 2'b00) $display("FAIL zero_fwd: fwd_a=%b expected=00", fwd_a);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (wb_wen !== 1'b0 || wb_wreg !== 5'd0)
      $display("FAIL zero_wb: wb_wen=%b wb_wreg=%0d expected 0 and 0", wb_wen, wb_wreg);
    else n_pass++;
  endtask

  task automatic test_freeze_flush();
    drive(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    freeze = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1);
    #1;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (mem_wreg !== 5'd5 || ex_wreg !== 5'd6 || fwd_a !== 2'b10 || fwd_b !== 2'b01)
        $display("FAIL freeze_hold%0d: mem=%0d ex=%0d fwd_a=%b fwd_b=%b expected 5 6 10 01",
                 c, mem_wreg, ex_wreg, fwd_a, fwd_b);
      else n_pass++;
      flush = 1'b1;
      tick();
      #1;
    end
    n_checks++;
    if (mem_wreg !== 5'd5 || ex_wreg !== 5'd6)
      $display("FAIL freeze_over_flush: mem=%0d ex=%0d expected 5 6", mem_wreg, ex_wreg);
    else n_pass++;
    freeze = 1'b0;
    drive(5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++;
    if (ex_wreg !== 5'd0) $display("FAIL flush_bubble: ex_wreg=%0d expected=0", ex_wreg);
    else n_pass++;
    flush = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (wb_wen !== 1'b0) $display("FAIL flush_wb: wb_wen=%b expected=0", wb_wen);
    else n_pass++;
  endtask

  task automatic test_priority();
    drive(5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    drive(5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
    #1;
    n_checks++;
    if (fwd_a !== 2'b01) $display("FAIL prio_ex_over_mem: fwd_a=%b expected=01", fwd_a);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (fwd_a !== 2'b10) $display("FAIL prio_mem_over_wb: fwd_a=%b expected=10", fwd_a);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (fwd_a !== WB_CODE) $display("FAIL prio_wb_only: fwd_a=%b expected=%b", fwd_a, WB_CODE);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    drive(5'd1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1);
    #1;
    n_checks++;
    if (dut_vec !== exp_vec()) $display("FAIL pre_reset_state: got=%h expected=%h", dut_vec, exp_vec());
    else n_pass++;
    #1;
    clrn = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (wb_wen !== 1'b0 || wb_wreg !== 5'd0 || lu_stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00)
      $display("FAIL async_reset_now: wb_wen=%b wb_wreg=%0d lu=%b fwd_a=%b fwd_b=%b expected all 0",
               wb_wen, wb_wreg, lu_stall, fwd_a, fwd_b);
    else n_pass++;
    tick();
    clrn = 1'b1;
    drive(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    n_checks++;
    if (wb_wen !== 1'b0) $display("FAIL reset_no_writeback: wb_wen=%b expected=0", wb_wen);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom));
      freeze = ($urandom_range(0, 9) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL random_cycle%0d: got=%h expected=%h", c, dut_vec, exp_vec());
      else n_pass++;
      tick();
    end
    freeze = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_freeze_flush();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
